uart_echo_fifo: RTL and testbench
=================================

Name: uart_echo_fifo

Overview:
- Echo buffer between the UART receiver and the UART transmitter. Replaces the single-element pending buffer with a parametrised FIFO.
- Adds a line-buffered release mode and optional upper-case conversion.
- Adds overflow detection with a saturating drop counter, plus a flush control.
- Sits in the top level: receiver data_ready/data_out drive its inputs; its tx_start/tx_data drive the transmitter.

Parameters:
- DATA_BITS, 8, width of each character.
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (default 16).
- TERM_CHAR, 8'h0D, terminator byte that releases a line in line mode.
- DROP_BITS, 8, width of the saturating drop counter.

Ports:
- clk_50MHz  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: received byte on rx_data.
- rx_data  in  DATA_BITS  received byte; valid only while rx_valid=1.
- tx_busy  in  1  transmitter frame in progress.
- tx_done_tick  in  1  one-cycle pulse at end of transmitter stop bit.
- line_mode  in  1  0 = per-character echo; 1 = release on TERM_CHAR.
- upcase  in  1  1 = convert 0x61..0x7A to 0x41..0x5A on write.
- flush  in  1  one-cycle pulse: discard FIFO contents, clear status.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_data  out  DATA_BITS  byte to transmit; held stable until next tx_start.
- fifo_count  out  DEPTH_LOG2+1  entries stored (0..DEPTH).
- fifo_empty  out  1  fifo_count==0.
- fifo_full  out  1  fifo_count==DEPTH.
- overflow  out  1  sticky: at least one byte dropped.
- drop_count  out  DROP_BITS  bytes dropped; saturates at all-ones.

Behaviour:
- Reset (synchronous, highest priority): pointers=0, commit pointer=0, fifo_count=0, tx_start=0, tx_data=0, overflow=0, drop_count=0, FSM=IDLE. fifo_empty=1, fifo_full=0.
- Write: on rx_valid=1 the byte is written if fifo_full=0, or if a pop occurs in the same cycle.
  - upcase=1 subtracts 0x20 from bytes in 0x61..0x7A before storage; all other bytes pass unchanged.
  - A byte that is not written increments drop_count (saturating) and sets overflow.
- Commit pointer: only committed bytes may be popped.
  - line_mode=0: every written byte is committed on the same edge.
  - line_mode=1: bytes stay uncommitted until a stored byte equals TERM_CHAR (compared after conversion). That write commits everything up to and including the terminator.
  - line_mode=1 and a write makes the FIFO full: commit all entries (forced release, no deadlock).
  - line_mode falling 1->0: all stored bytes are committed on the next edge.
- FSM states: IDLE, LOAD, START, WAIT_DONE.
  - IDLE: if committed entries>0 and tx_busy=0, go to LOAD.
  - LOAD: pop the head entry into tx_data, then go to START.
  - START: tx_start=1 for exactly this cycle, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_done_tick=1, then go to IDLE.
- Latency: rx_valid in cycle n into an empty FIFO with the transmitter idle (char mode) gives tx_start=1 in cycle n+3, with tx_data valid from n+3.
- Back-to-back: the next tx_start comes no earlier than 3 cycles after tx_done_tick.
- Simultaneous write and pop: count is unchanged; a write into a full FIFO during a LOAD pop is accepted.
- Flush (priority below reset, above write):
  - Pointers, commit, count, overflow and drop_count cleared; an rx_valid byte in the same cycle is discarded and not counted as a drop.
  - FSM in LOAD returns to IDLE with no pop and no start.
  - START and WAIT_DONE complete normally, so an in-flight frame is never aborted.
- Pointer wrap-around: modulo DEPTH; fifo_count gives the full/empty distinction.
- tx_start never asserts while tx_busy=1 is sampled in IDLE.

Test Plan:
- Char mode: rx_valid with 0x41 while idle -> tx_start in cycle n+3 with tx_data=0x41; after tx_done_tick, fifo_empty=1.
- Burst of 5 bytes 0x31..0x35, one every 10 cycles, while the transmitter is busy for 1000 cycles -> fifo_count=5, echoes in order 0x31..0x35, one tx_start per tx_done_tick.
- line_mode=1, upcase=1: write "ab" then 0x0D -> no tx_start before 0x0D. Then echoes 0x41, 0x42, 0x0D.
- Overflow at DEPTH=16, transmitter busy: write 20 bytes -> fifo_full=1, overflow=1, drop_count=4, bytes 17..20 never echoed. Then flush pulse -> fifo_count=0, overflow=0, drop_count=0.
- line_mode=1 with 16 bytes and no terminator -> forced commit, all 16 echoed. Separately, 3 bytes stored then line_mode 1->0 -> 3 bytes echoed.
- Reset mid-WAIT_DONE with 4 entries stored -> the next cycle shows tx_start=0, fifo_count=0, FSM in IDLE, and no echo follows.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// Echo buffer between UART receiver and transmitter: a committed-entry FIFO
// with per-character or line-buffered release, optional upper-casing,
// saturating drop counter and flush.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for a committed entry and an idle transmitter
// S_LOAD    | pop head entry into tx_data (flush aborts without pop)
// S_START   | tx_start pulse for exactly one cycle
// S_WAIT    | frame in flight, wait for tx_done_tick
module uart_echo_fifo #(
  parameter int                   DATA_BITS  = 8,
  parameter int                   DEPTH_LOG2 = 4,
  parameter logic [DATA_BITS-1:0] TERM_CHAR  = DATA_BITS'(8'h0D),
  parameter int                   DROP_BITS  = 8
) (
  input  logic                  clk_50MHz,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [DATA_BITS-1:0]  rx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done_tick,
  input  logic                  line_mode,
  input  logic                  upcase,
  input  logic                  flush,
  output logic                  tx_start,
  output logic [DATA_BITS-1:0]  tx_data,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  overflow,
  output logic [DROP_BITS-1:0]  drop_count
);

  localparam int                   DEPTH     = 1 << DEPTH_LOG2;
  localparam int                   CW        = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]        DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DATA_BITS-1:0] LC_FIRST  = DATA_BITS'(8'h61);
  localparam logic [DATA_BITS-1:0] LC_LAST   = DATA_BITS'(8'h7A);
  localparam logic [DATA_BITS-1:0] CASE_OFS  = DATA_BITS'(8'h20);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          commit_q, commit_d;
  logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_BITS-1:0]   drop_q, drop_d;
  logic                   pop;
  logic                   wr_en;
  logic [DATA_BITS-1:0]   wdata;

  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign tx_data    = tx_data_q;

  // Case conversion and write acceptance; a same-cycle pop frees a slot.
  always_comb begin
    wdata = rx_data;
    if (upcase && (rx_data >= LC_FIRST) && (rx_data <= LC_LAST)) begin
      wdata = rx_data - CASE_OFS;
    end
    wr_en = rx_valid && !flush && (!fifo_full || pop);
  end

  // Next-state and outputs of the transmit sequencer.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    tx_start  = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        // flush in the same cycle empties the FIFO, so do not commit to a load
        if (!flush && (commit_q != '0) && !tx_busy) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_start = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer, occupancy, commit and drop bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    commit_d   = commit_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      commit_d   = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (pop)   rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (wr_en && !pop)      count_d = count_q + CW'(1);
      else if (!wr_en && pop) count_d = count_q - CW'(1);
      if (pop) commit_d = commit_q - CW'(1);
      // Char mode commits everything stored, which also releases any line
      // left pending when line_mode drops.
      if (!line_mode) begin
        commit_d = count_d;
      end else if (wr_en && ((wdata == TERM_CHAR) || (count_d == DEPTH_CNT))) begin
        commit_d = count_d;
      end
      if (rx_valid && !wr_en) begin
        overflow_d = 1'b1;
        if (drop_q != {DROP_BITS{1'b1}}) drop_d = drop_q + DROP_BITS'(1);
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      commit_q   <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      commit_q   <= commit_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk_50MHz) begin
    if (!reset && wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: queue-based reference model compared every
// cycle, a simple transmitter stand-in, directed scenarios and random traffic.
module tb_uart_echo_fifo;

  localparam int         DEPTH = 16;
  localparam logic [7:0] TERM  = 8'h0D;
  localparam int E_IDLE = 0, E_LOAD = 1, E_START = 2, E_WAIT = 3;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic       line_mode = 1'b0;
  logic       upcase = 1'b0;
  logic       flush = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;
  logic [7:0] drop_count;

  uart_echo_fifo dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .line_mode(line_mode),
    .upcase(upcase), .flush(flush), .tx_start(tx_start), .tx_data(tx_data),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored bytes, a count of releasable bytes
  // at its head, and the echo engine phase.
  logic [7:0] mq[$];
  int         m_commit = 0;
  int         m_drop = 0;
  bit         m_ovf = 0;
  logic [7:0] m_txd = 8'h00;
  int         m_eng = E_IDLE;
  bit         m_on = 0;

  always @(posedge clk_50MHz) begin
    logic [7:0] b;
    if (reset) begin
      mq.delete(); m_commit = 0; m_ovf = 0; m_drop = 0; m_txd = 8'h00;
      m_eng = E_IDLE; m_on = 1;
    end else begin
      case (m_eng)
        E_IDLE:  if (!flush && m_commit > 0 && !tx_busy) m_eng = E_LOAD;
        E_LOAD:  if (flush) m_eng = E_IDLE;
                 else begin m_txd = mq.pop_front(); m_commit--; m_eng = E_START; end
        E_START: m_eng = E_WAIT;
        default: if (tx_done_tick) m_eng = E_IDLE;
      endcase
      if (flush) begin
        mq.delete(); m_commit = 0; m_ovf = 0; m_drop = 0;
      end else if (rx_valid) begin
        b = rx_data;
        if (upcase && b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
        if (mq.size() < DEPTH) begin
          mq.push_back(b);
          if (b == TERM || mq.size() == DEPTH) m_commit = mq.size();
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (!line_mode) m_commit = mq.size();
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk_50MHz) begin
    if (m_on) begin
      chk("tx_start",   int'(tx_start),   int'(m_eng == E_START));
      chk("tx_data",    int'(tx_data),    int'(m_txd));
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("fifo_empty", int'(fifo_empty), int'(mq.size() == 0));
      chk("fifo_full",  int'(fifo_full),  int'(mq.size() == DEPTH));
      chk("overflow",   int'(overflow),   int'(m_ovf));
      chk("drop_count", int'(drop_count), m_drop);
    end
  end

  // Transmitter stand-in and echo capture.
  logic [7:0] echoed[$];
  int  bt_rem = 0;
  int  frame_len = 12;
  bit  hold_busy = 0;
  bit  rand_len = 0;

  task automatic cyc();
    @(negedge clk_50MHz); #1;
    tx_done_tick = 1'b0;
    if (bt_rem > 0) begin
      bt_rem--;
      if (bt_rem == 0) tx_done_tick = 1'b1;
    end
    if (tx_start) begin
      echoed.push_back(tx_data);
      bt_rem = rand_len ? $urandom_range(1, 8) : frame_len;
    end
    tx_busy = hold_busy || (bt_rem > 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic wait_echoes(input string nm, input int n, input int budget);
    int i = 0;
    while (echoed.size() < n && i < budget) begin cyc(); i++; end
    chk(nm, echoed.size(), n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    int base, k;
    bit found;

    idle(3);
    reset = 1'b0;
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_full",  int'(fifo_full), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_start", int'(tx_start), 0);
    chk("rst_data",  int'(tx_data), 0);
    chk("rst_ovf",   int'(overflow), 0);
    chk("rst_drop",  int'(drop_count), 0);
    idle(2);

    // Char-mode latency: tx_start three cycles after the write cycle.
    base = echoed.size();
    rx_valid = 1'b1; rx_data = 8'h41;
    k = 0; found = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      cyc(); rx_valid = 1'b0;
      if (tx_start) begin found = 1; k = i; end
    end
    chk("latency", k, 3);
    chk("lat_data", int'(tx_data), 8'h41);
    idle(20);
    chk("lat_empty", int'(fifo_empty), 1);

    // Burst while the transmitter is held busy.
    base = echoed.size();
    hold_busy = 1; tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin wr(8'h31 + 8'(i)); idle(9); end
    idle(950);
    chk("burst_count", int'(fifo_count), 5);
    chk("burst_noecho", echoed.size(), base);
    hold_busy = 0;
    wait_echoes("burst_echoes", base + 5, 400);
    for (int i = 0; i < 5; i++) chk("burst_order", int'(echoed[base + i]), 8'h31 + i);
    idle(20);

    // Line mode with upper-casing.
    base = echoed.size();
    line_mode = 1'b1; upcase = 1'b1;
    wr(8'h61); idle(5); wr(8'h62); idle(10);
    chk("line_hold", echoed.size(), base);
    chk("line_count", int'(fifo_count), 2);
    wr(8'h0D);
    wait_echoes("line_echoes", base + 3, 300);
    chk("line_e0", int'(echoed[base]), 8'h41);
    chk("line_e1", int'(echoed[base + 1]), 8'h42);
    chk("line_e2", int'(echoed[base + 2]), 8'h0D);
    idle(20);
    line_mode = 1'b0; upcase = 1'b0;
    idle(2);

    // Overflow: 20 writes into 16 entries, only the first 16 echoed.
    base = echoed.size();
    hold_busy = 1; tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin wr(8'h50 + 8'(i)); cyc(); end
    chk("ovf_full", int'(fifo_full), 1);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_drop", int'(drop_count), 4);
    chk("ovf_count", int'(fifo_count), 16);
    hold_busy = 0;
    wait_echoes("ovf_echoes", base + 16, 600);
    idle(50);
    chk("ovf_total", echoed.size(), base + 16);
    chk("ovf_last", int'(echoed[base + 15]), 8'h5F);

    // Flush after overflow clears everything; nothing echoes afterwards.
    base = echoed.size();
    hold_busy = 1; tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) wr(8'h20 + 8'(i));
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_count", int'(fifo_count), 0);
    chk("flush_ovf", int'(overflow), 0);
    chk("flush_drop", int'(drop_count), 0);
    hold_busy = 0;
    idle(100);
    chk("flush_noecho", echoed.size(), base);

    // Forced release of a full unterminated line.
    base = echoed.size();
    line_mode = 1'b1;
    for (int i = 0; i < 15; i++) wr(8'h40 + 8'(i));
    chk("force_pre", int'(fifo_count), 15);
    wr(8'h4F);
    wait_echoes("force_echoes", base + 16, 600);
    chk("force_first", int'(echoed[base]), 8'h40);
    chk("force_last", int'(echoed[base + 15]), 8'h4F);
    idle(20);

    // Pending line released when line_mode drops.
    base = echoed.size();
    wr(8'h70); wr(8'h71); wr(8'h72); idle(10);
    chk("drop_hold", echoed.size(), base);
    line_mode = 1'b0;
    wait_echoes("drop_echoes", base + 3, 300);
    chk("drop_e2", int'(echoed[base + 2]), 8'h72);
    idle(20);

    // Reset during a long frame with four entries waiting.
    frame_len = 200;
    for (int i = 0; i < 5; i++) wr(8'h61 + 8'(i));
    idle(10);
    chk("mid_count", int'(fifo_count), 4);
    base = echoed.size();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("mid_start", int'(tx_start), 0);
    chk("mid_cnt0", int'(fifo_count), 0);
    chk("mid_empty", int'(fifo_empty), 1);
    idle(400);
    chk("mid_noecho", echoed.size(), base);
    frame_len = 12;

    // Random traffic against the model.
    rand_len = 1;
    for (int i = 0; i < 5000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      rx_valid = ($urandom_range(0, 99) < 45);
      case ($urandom_range(0, 3))
        0: rx_data = TERM;
        1: rx_data = 8'($urandom_range(8'h61, 8'h7A));
        default: rx_data = 8'($urandom);
      endcase
      if ($urandom_range(0, 99) < 3) line_mode = ~line_mode;
      if ($urandom_range(0, 99) < 3) upcase = ~upcase;
      flush = (r < 8);
      reset = (r == 999);
      if ($urandom_range(0, 199) == 0) hold_busy = ~hold_busy;
      cyc();
    end
    rx_valid = 1'b0; flush = 1'b0; reset = 1'b0; hold_busy = 0;
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
